count_capture: RTL and testbench
================================

# count_capture

Timestamp capture stage that sits directly downstream of the 8-bit free-running counter. On each rising edge of `trig` it samples the counter value and computes the modulo-2^WIDTH delta from the previously stored capture. It buffers {raw, delta} pairs in a small show-ahead FIFO and presents them on a valid/ready output port. Overflow is reported through a sticky flag.

## Interface
- `WIDTH`, 8: width of the counter value, `dout` and `ddelta`.
- `DEPTH`, 4: number of FIFO entries; must be a power of two and at least 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `count_in` input WIDTH: counter value from the upstream counter.
- `trig` input 1: capture request; level signal, edge-detected internally; synchronous to `clk`.
- `clr_ovf` input 1: synchronous clear of `overflow`.
- `dout` output WIDTH: raw captured count at the FIFO head.
- `ddelta` output WIDTH: head entry's delta, `(raw - prev_accepted) mod 2^WIDTH`.
- `dout_valid` output 1: head entry is present.
- `dout_ready` input 1: consumer accepts the head entry.
- `empty` output 1: FIFO holds 0 entries.
- `full` output 1: FIFO holds DEPTH entries.
- `level` output log2(DEPTH)+1: number of stored entries.
- `overflow` output 1: sticky flag; a capture was dropped.

## Operation
- **Edge detect.** Register `trig_q <= trig`. A capture event is `trig & ~trig_q`. `trig_q` resets to 1, so `trig` held high through reset release causes no capture until it has been seen low.
- **Capture.** On an event, the entry is {`count_in`, `count_in - prev`} using the `count_in` value of that same cycle. Subtraction is WIDTH-bit modulo (wrap-around is natural, e.g. prev 250, raw 4 gives delta 10).
- **`prev` register.** Resets to 0 and updates to raw only when the entry is accepted into the FIFO. The first capture after reset therefore has delta = raw. Dropped captures do not update `prev`.
- **Pop.** `pop = dout_valid & dout_ready`.
- **Push acceptance.** A push is accepted when the FIFO is not full, or when full and a pop occurs in the same cycle.
- **Drop and overflow.**
  - A push while full with no pop drops the entry and sets `overflow`.
  - `overflow` stays set until `rst`, or until `clr_ovf` is high.
  - If `clr_ovf` and a new drop occur in the same cycle, `overflow` ends set (set wins).
- **Outputs.**
  - Show-ahead: `dout`/`ddelta` reflect the head entry whenever `dout_valid` is 1.
  - `dout`/`ddelta` are forced to 0 when `dout_valid` is 0.
  - `dout_valid = ~empty`.
- **Pointers.** Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - `level` increments on an accepted push without pop and decrements on a pop without push.
  - `level` is unchanged on simultaneous push and pop.
- **Flags.** `empty = (level == 0)`; `full = (level == DEPTH)`. Both are derived from the registered `level`.
- **Reset values.**
  - Pointers and `level` = 0; `prev` = 0; `trig_q` = 1.
  - `overflow` = 0; `dout_valid` = 0; `empty` = 1; `full` = 0.
  - `dout` = 0; `ddelta` = 0.
  - FIFO storage contents are don't-care.

## Timing
- **Capture latency.** Event at cycle N (edge seen at the clock edge ending cycle N): the entry is written at that edge. With the FIFO previously empty, `dout_valid`=1 and `dout` = `count_in`(N) during cycle N+1.
- **Pop latency.** A pop at the edge ending cycle M presents the next entry, or deasserts `dout_valid`, in cycle M+1.
- **Throughput.** Minimum spacing between capture events is 2 cycles, because `trig` must return low. The FIFO sustains one push and one pop per cycle.
- **`dout_ready`.** Unconstrained. It may be held high continuously; it is ignored when `dout_valid` is 0.
- **Empty + capture.** A capture event on an empty FIFO with `dout_ready` high is not bypassed; it becomes visible the following cycle.
- **Reset mid-operation.** `rst` high at any edge discards all entries and overflow state and returns every output to its reset value in the next cycle. A capture event coincident with `rst` is ignored.

## Test plan
- **Basic capture.** Reset, counter free-running from 0, `dout_ready`=0; pulse `trig` when `count_in`=5, then at 12 -> `level`=2; head `dout`=5, `ddelta`=5; after one pop `dout`=12, `ddelta`=7.
- **Wrap-around.** Captures at 250, then 4 -> second entry `ddelta`=10; third capture at 4+256 cycles later (value 4) -> `ddelta`=0.
- **Overflow.** DEPTH=4, `dout_ready`=0, 5 captures at 10, 20, 30, 40, 50 -> `full`=1 after the 4th; 5th dropped, `overflow`=1, `level`=4.
  - Drain: entries 10, 20, 30, 40.
  - Next capture at 60 -> `ddelta`=20, since `prev` is 40.
  - `clr_ovf` pulse -> `overflow`=0.
- **Full with simultaneous pop.** FIFO full, `dout_ready`=1 on the same cycle as a capture at 77 -> push accepted, `level` stays 4, `overflow` stays 0, 77 emerges after the three older entries.
- **Trig held through reset.** Hold `trig` high through reset release -> no capture. Drop `trig` and raise it again at count 9 -> one entry, `dout`=9, `ddelta`=9.
- **Reset mid-operation.** 3 entries stored, `overflow`=1, assert `rst` for 1 cycle -> next cycle `dout_valid`=0, `level`=0, `overflow`=0, `dout`=0. First new capture has `ddelta` equal to its raw value.

Source files
------------

// File: rtl/count_capture.sv
// count_capture: edge-triggered timestamp capture of a free-running counter into
// a show-ahead FIFO of {raw, delta} pairs, with a sticky overflow flag.
module count_capture #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       count_in,
    input  logic                   trig,
    input  logic                   clr_ovf,
    output logic [WIDTH-1:0]       dout,
    output logic [WIDTH-1:0]       ddelta,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_raw [DEPTH];
    logic [WIDTH-1:0] mem_dlt [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] cap_delta;
    logic             trig_q;
    logic             cap_ev;
    logic             pop;
    logic             push;
    logic             drop;

    assign cap_ev     = trig & ~trig_q;
    assign cap_delta  = count_in - prev;
    assign empty      = (level == '0);
    assign full       = (level == LVL_FULL);
    assign dout_valid = ~empty;
    assign pop        = dout_valid & dout_ready;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign push       = cap_ev & (~full | pop);
    assign drop       = cap_ev & full & ~pop;
    assign dout       = dout_valid ? mem_raw[rd_ptr] : '0;
    assign ddelta     = dout_valid ? mem_dlt[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q   <= 1'b1;
            prev     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            trig_q <= trig;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                prev   <= count_in;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                level <= level + LVL_ONE;
            end else if (pop && !push) begin
                level <= level - LVL_ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_raw[wr_ptr] <= count_in;
            mem_dlt[wr_ptr] <= cap_delta;
        end
    end
endmodule

// File: tb/tb_count_capture.sv
// Bench for count_capture: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_count_capture;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       dout_ready = 1'b0;
    logic [7:0] count_in = '0;
    logic [7:0] dout;
    logic [7:0] ddelta;
    logic       dout_valid;
    logic       empty;
    logic       full;
    logic [2:0] level;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;
    bit mchk    = 1'b0;

    typedef struct packed {
        logic [7:0] raw;
        logic [7:0] dl;
    } ent_t;

    ent_t       mq[$];
    logic [7:0] m_prev  = '0;
    logic       m_trigq = 1'b1;
    logic       m_ovf   = 1'b0;

    count_capture #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .trig(trig), .clr_ovf(clr_ovf),
        .dout(dout), .ddelta(ddelta), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .empty(empty), .full(full), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference behaviour of one clock edge, from the block's rules.
    task automatic model_step(input logic r, input logic t, input logic rd, input logic c,
                              input logic [7:0] cnt);
        int  sz;
        bit  ev;
        bit  pm;
        if (r) begin
            mq.delete();
            m_prev  = '0;
            m_trigq = 1'b1;
            m_ovf   = 1'b0;
        end else begin
            sz = mq.size();
            ev = t && !m_trigq;
            pm = (sz > 0) && rd;
            if (pm) void'(mq.pop_front());
            if (ev && (sz < 4 || pm)) begin
                mq.push_back({cnt, 8'(cnt - m_prev)});
                m_prev = cnt;
            end
            if (ev && sz == 4 && !pm) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
            m_trigq = t;
        end
    endtask

    task automatic cyc(input logic r, input logic t, input logic rd, input logic c,
                       input logic [7:0] cnt);
        ent_t h;
        rst = r; trig = t; dout_ready = rd; clr_ovf = c; count_in = cnt;
        @(posedge clk);
        #1;
        model_step(r, t, rd, c, cnt);
        if (mchk) begin
            h = (mq.size() > 0) ? mq[0] : '0;
            chk("rnd_valid", dout_valid, mq.size() > 0);
            chk("rnd_dout", dout, h.raw);
            chk("rnd_ddelta", ddelta, h.dl);
            chk("rnd_level", level, mq.size());
            chk("rnd_full", full, mq.size() == 4);
            chk("rnd_empty", empty, mq.size() == 0);
            chk("rnd_overflow", overflow, m_ovf);
        end
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic cap(input logic [7:0] v);
        cyc(0, 1, 0, 0, v);
        cyc(0, 0, 0, 0, 8'(v + 1));
    endtask

    task automatic head(input string nm, input logic [7:0] d, input logic [7:0] dl);
        chk({nm, "_valid"}, dout_valid, 1);
        chk({nm, "_dout"}, dout, d);
        chk({nm, "_ddelta"}, ddelta, dl);
    endtask

    typedef struct {
        logic       t;
        logic       rd;
        logic [7:0] cnt;
        logic       e_valid;
        logic [7:0] e_dout;
        logic [7:0] e_dl;
        logic [2:0] e_lvl;
    } vec_t;

    vec_t vt[13];

    initial begin
        vt[0]  = '{1, 0,   5, 1,   5,   5, 1};
        vt[1]  = '{0, 0,   6, 1,   5,   5, 1};
        vt[2]  = '{1, 0,  12, 1,   5,   5, 2};
        vt[3]  = '{0, 0,  13, 1,   5,   5, 2};
        vt[4]  = '{0, 1,  14, 1,  12,   7, 1};
        vt[5]  = '{0, 1,  15, 0,   0,   0, 0};
        vt[6]  = '{1, 1, 250, 1, 250, 238, 1};
        vt[7]  = '{0, 0, 251, 1, 250, 238, 1};
        vt[8]  = '{1, 0,   4, 1, 250, 238, 2};
        vt[9]  = '{0, 1,   5, 1,   4,  10, 1};
        vt[10] = '{0, 1,   6, 0,   0,   0, 0};
        vt[11] = '{1, 0,   4, 1,   4,   0, 1};
        vt[12] = '{0, 1,   5, 0,   0,   0, 0};

        // Reset values
        cyc(1, 0, 0, 0, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_dout", dout, 0);
        chk("rst_ddelta", ddelta, 0);
        do_reset();

        // Basic capture, empty+capture without bypass, wrap-around deltas
        foreach (vt[i]) begin
            cyc(0, vt[i].t, vt[i].rd, 0, vt[i].cnt);
            chk($sformatf("vec%0d_valid", i), dout_valid, vt[i].e_valid);
            chk($sformatf("vec%0d_dout", i), dout, vt[i].e_dout);
            chk($sformatf("vec%0d_ddelta", i), ddelta, vt[i].e_dl);
            chk($sformatf("vec%0d_level", i), level, vt[i].e_lvl);
            chk($sformatf("vec%0d_ovf", i), overflow, 0);
        end

        // Overflow, drain, prev unaffected by drop, clear
        do_reset();
        cap(10); cap(20); cap(30); cap(40);
        chk("ovf_full4", full, 1);
        chk("ovf_level4", level, 4);
        chk("ovf_pre", overflow, 0);
        cap(50);
        chk("ovf_set", overflow, 1);
        chk("ovf_level_after_drop", level, 4);
        for (int i = 0; i < 4; i++) begin
            head($sformatf("drain%0d", i), 8'(10 * (i + 1)), 10);
            cyc(0, 0, 1, 0, 0);
        end
        chk("drain_empty", empty, 1);
        cap(60);
        head("after_drop", 60, 20);
        chk("ovf_sticky", overflow, 1);
        cyc(0, 0, 0, 1, 0);
        chk("ovf_clr", overflow, 0);

        // Clear and drop in the same cycle: set wins
        cap(70); cap(71); cap(72);
        chk("refill_full", full, 1);
        cyc(0, 1, 0, 1, 73);
        chk("set_wins", overflow, 1);
        cyc(0, 0, 0, 0, 74);
        cyc(0, 0, 0, 1, 0);
        chk("set_wins_clr", overflow, 0);

        // Full with simultaneous pop and capture
        cyc(0, 1, 1, 0, 77);
        chk("fullpop_level", level, 4);
        chk("fullpop_ovf", overflow, 0);
        cyc(0, 0, 0, 0, 78);
        begin
            logic [7:0] er[4] = '{70, 71, 72, 77};
            logic [7:0] ed[4] = '{10, 1, 1, 5};
            for (int i = 0; i < 4; i++) begin
                head($sformatf("fullpop%0d", i), er[i], ed[i]);
                cyc(0, 0, 1, 0, 0);
            end
        end
        chk("fullpop_empty", empty, 1);

        // Trig held high through reset release
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 2);
        cyc(0, 1, 0, 0, 3);
        cyc(0, 1, 0, 0, 4);
        chk("held_nocap", level, 0);
        cyc(0, 0, 0, 0, 8);
        cyc(0, 1, 0, 0, 9);
        chk("held_level", level, 1);
        head("held", 9, 9);

        // Reset mid-operation, coincident capture ignored
        do_reset();
        cap(1); cap(2); cap(3); cap(4); cap(5);
        cyc(0, 0, 1, 0, 6);
        chk("mid_level3", level, 3);
        chk("mid_ovf1", overflow, 1);
        cyc(1, 1, 0, 0, 99);
        chk("mid_valid", dout_valid, 0);
        chk("mid_level", level, 0);
        chk("mid_ovf", overflow, 0);
        chk("mid_dout", dout, 0);
        chk("mid_ddelta", ddelta, 0);
        cyc(0, 1, 0, 0, 100);
        chk("mid_nocap", level, 0);
        cyc(0, 0, 0, 0, 101);
        cap(33);
        head("mid_first", 33, 33);

        // Randomized traffic against the reference model
        do_reset();
        mchk = 1'b1;
        begin
            logic [7:0] cnt = '0;
            for (int i = 0; i < 4000; i++) begin
                cyc($urandom_range(0, 299) == 0,
                    $urandom_range(0, 9) < 4,
                    $urandom_range(0, 9) < 3,
                    $urandom_range(0, 29) == 0,
                    cnt);
                cnt = cnt + 8'd1;
            end
        end
        mchk = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
